// File: rtl/ifm_skew_feeder_pkg.sv
// Shared types and constants for the ifm skew feeder.
package feeder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int MAC_CYC_DEFAULT = 256;

  // Window counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifm_skew_feeder_if.sv
// Upstream handshake plus array-side row bus of the ifm skew feeder.
interface ifm_skew_feeder_if #(
  parameter int HEIGHT = 4,
  parameter int IWIDTH = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_first;
  logic signed [IWIDTH-1:0] in_ifm [HEIGHT];
  logic signed [IWIDTH-1:0] ifm [HEIGHT];
  logic [HEIGHT-1:0]        en_i;
  logic [HEIGHT-1:0]        clr_i;
  logic [HEIGHT-1:0]        mac_done;
  logic                     busy;

  modport master (
    output in_valid, in_first, in_ifm,
    input  in_ready, ifm, en_i, clr_i, mac_done, busy
  );

  modport slave (
    input  in_valid, in_first, in_ifm,
    output in_ready, ifm, en_i, clr_i, mac_done, busy
  );
endinterface

// File: rtl/ifm_skew_feeder_skew_delay.sv
// Registered delay line of depth D and width W; depth 0 degenerates to a wire.
module skew_delay #(
  parameter int D = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  generate
    if (D == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_line
      logic [W-1:0] stage_reg [D];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= d;
          for (int i = 1; i < D; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign q = stage_reg[D-1];
    end
  endgenerate
endmodule

// File: rtl/ifm_skew_feeder.sv
// Holds each accepted ifm vector for a MAC_CYC window and skews rows diagonally.
// Optional FEEDER_PERF_CNT_EN adds a saturating completed-window counter (perf_win).
module ifm_skew_feeder
  import feeder_pkg::*;
#(
  parameter int HEIGHT  = 4,
  parameter int IWIDTH  = 16,
  parameter int MAC_CYC = MAC_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  ifm_skew_feeder_if.slave  bus
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]       perf_win
`endif
);
  localparam int CNTW = cnt_width(MAC_CYC);
  localparam int DW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(MAC_CYC - 1);
  localparam logic [CNTW-1:0] CNT_PEN    = CNTW'(MAC_CYC - 2);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'((HEIGHT > 1) ? HEIGHT - 2 : 0);
  localparam bit              HAS_DRAIN  = (HEIGHT > 1);

  state_t                   state_reg;
  logic [CNTW-1:0]          cnt_reg;
  logic [DW-1:0]            dcnt_reg;
  logic                     en0_reg;
  logic                     clr0_reg;
  logic                     done0_reg;
  logic signed [IWIDTH-1:0] hold_reg [HEIGHT];
  logic                     ready;
  logic                     accept;

  // Ready in IDLE, or on the last window cycle so windows chain without a bubble.
  assign ready      = (state_reg == IDLE) || ((state_reg == RUN) && (cnt_reg == CNT_LAST));
  assign accept     = bus.in_valid && ready;
  assign bus.in_ready = ready;
  assign bus.busy     = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dcnt_reg  <= '0;
      en0_reg   <= 1'b0;
      clr0_reg  <= 1'b0;
      done0_reg <= 1'b0;
      for (int h = 0; h < HEIGHT; h++) hold_reg[h] <= '0;
    end else begin
      clr0_reg  <= 1'b0;
      done0_reg <= 1'b0;
      if (accept) begin
        state_reg <= RUN;
        cnt_reg   <= '0;
        en0_reg   <= 1'b1;
        clr0_reg  <= bus.in_first;
        for (int h = 0; h < HEIGHT; h++) hold_reg[h] <= bus.in_ifm[h];
      end else begin
        case (state_reg)
          RUN: begin
            if (cnt_reg == CNT_LAST) begin
              en0_reg <= 1'b0;
              if (HAS_DRAIN) begin
                state_reg <= DRAIN;
                dcnt_reg  <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              cnt_reg   <= cnt_reg + 1'b1;
              // Registered one cycle early so the pulse lands on the last window cycle.
              done0_reg <= (cnt_reg == CNT_PEN);
            end
          end
          DRAIN: begin
            if (dcnt_reg == DRAIN_LAST) state_reg <= IDLE;
            else                        dcnt_reg  <= dcnt_reg + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Row h sees the row-0 window h cycles later; its data enters only while the window is open.
  generate
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
      logic signed [IWIDTH-1:0] ifm_src;
      logic [IWIDTH-1:0]        ifm_dly;
      logic [2:0]               ctl_dly;

      assign ifm_src = en0_reg ? hold_reg[gi] : '0;

      skew_delay #(.D(gi), .W(3)) u_ctl (
        .clk (clk),
        .rst (rst),
        .d   ({en0_reg, clr0_reg, done0_reg}),
        .q   (ctl_dly)
      );

      skew_delay #(.D(gi), .W(IWIDTH)) u_ifm (
        .clk (clk),
        .rst (rst),
        .d   (ifm_src),
        .q   (ifm_dly)
      );

      assign bus.en_i[gi]     = ctl_dly[2];
      assign bus.clr_i[gi]    = ctl_dly[1];
      assign bus.mac_done[gi] = ctl_dly[0];
      assign bus.ifm[gi]      = $signed(ifm_dly);
    end
  endgenerate

`ifdef FEEDER_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_win <= '0;
    end else if (bus.mac_done[HEIGHT-1] && (perf_win != 32'hFFFF_FFFF)) begin
      perf_win <= perf_win + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Randomized bench for ifm_skew_feeder against a window-list reference model.
module tb_ifm_skew_feeder;
  localparam int HEIGHT  = 4;
  localparam int IWIDTH  = 16;
  localparam int MAC_CYC = 8;

  typedef struct {
    int                       k;
    bit                       first;
    logic signed [IWIDTH-1:0] v [HEIGHT];
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifm_skew_feeder_if #(.HEIGHT(HEIGHT), .IWIDTH(IWIDTH)) bus ();

  ifm_skew_feeder #(
    .HEIGHT  (HEIGHT),
    .IWIDTH  (IWIDTH),
    .MAC_CYC (MAC_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  win_t                     wins [$];
  int                       cyc   = 0;
  int                       tests = 0;
  int                       fails = 0;
  bit                       drv_valid;
  bit                       drv_first;
  logic signed [IWIDTH-1:0] drv_ifm [HEIGHT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Accepted windows since the last reset; a window accepted at cycle k occupies
  // row h during cycles k+1+h .. k+MAC_CYC+h.
  function automatic bit model_ready(input int t);
    int kl;
    if (wins.size() == 0) return 1'b1;
    kl = wins[wins.size()-1].k;
    return (t == kl + MAC_CYC) || (t >= kl + MAC_CYC + HEIGHT);
  endfunction

  function automatic bit model_busy(input int t);
    int kl;
    if (wins.size() == 0) return 1'b0;
    kl = wins[wins.size()-1].k;
    return (t > kl) && (t < kl + MAC_CYC + HEIGHT);
  endfunction

  task automatic check_cycle();
    logic [HEIGHT-1:0]        e_en;
    logic [HEIGHT-1:0]        e_clr;
    logic [HEIGHT-1:0]        e_done;
    logic signed [IWIDTH-1:0] e_ifm [HEIGHT];
    int                       s;
    e_en = '0; e_clr = '0; e_done = '0;
    for (int h = 0; h < HEIGHT; h++) e_ifm[h] = '0;
    foreach (wins[i]) begin
      for (int h = 0; h < HEIGHT; h++) begin
        s = wins[i].k + 1 + h;
        if (cyc >= s && cyc <= s + MAC_CYC - 1) begin
          e_en[h]  = 1'b1;
          e_ifm[h] = wins[i].v[h];
          if (wins[i].first && cyc == s) e_clr[h] = 1'b1;
          if (cyc == s + MAC_CYC - 1)    e_done[h] = 1'b1;
        end
      end
    end
    check("in_ready", 64'(bus.in_ready), 64'(model_ready(cyc)));
    check("busy",     64'(bus.busy),     64'(model_busy(cyc)));
    check("en_i",     64'(bus.en_i),     64'(e_en));
    check("clr_i",    64'(bus.clr_i),    64'(e_clr));
    check("mac_done", 64'(bus.mac_done), 64'(e_done));
    for (int h = 0; h < HEIGHT; h++)
      check($sformatf("ifm[%0d]", h), 64'(bus.ifm[h]), 64'(e_ifm[h]));
  endtask

  task automatic step();
    win_t w;
    @(negedge clk);
    check_cycle();
    bus.in_valid = drv_valid;
    bus.in_first = drv_first;
    for (int h = 0; h < HEIGHT; h++) bus.in_ifm[h] = drv_ifm[h];
    if (!rst && drv_valid && model_ready(cyc)) begin
      w.k = cyc;
      w.first = drv_first;
      w.v = drv_ifm;
      wins.push_back(w);
      while (wins.size() > 3) void'(wins.pop_front());
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_cycle();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    wins.delete();
    #1;
    check_cycle();
    cyc++;
    repeat (2) begin
      @(negedge clk);
      check_cycle();
      cyc++;
    end
    rst = 1'b0;
  endtask

  task automatic rand_vec();
    for (int h = 0; h < HEIGHT; h++) drv_ifm[h] = IWIDTH'($urandom);
  endtask

  task automatic plan_vec();
    drv_ifm[0] = -16'sd3;
    drv_ifm[1] = 16'sd5;
    drv_ifm[2] = 16'sd7;
    drv_ifm[3] = -16'sd1;
  endtask

  initial begin
    drv_valid = 1'b0;
    drv_first = 1'b0;
    rand_vec();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    for (int h = 0; h < HEIGHT; h++) bus.in_ifm[h] = '0;
    repeat (3) step();
    rst = 1'b0;

    // Single vector handshaken at cycle 10.
    while (cyc < 10) step();
    plan_vec();
    drv_valid = 1'b1;
    drv_first = 1'b1;
    step();
    drv_valid = 1'b0;
    repeat (20) step();

    // Back-to-back windows, then a gap with in_valid held high through DRAIN.
    drv_valid = 1'b1;
    drv_first = 1'b1;
    rand_vec();
    step();
    drv_first = 1'b0;
    repeat (8) begin rand_vec(); step(); end
    drv_valid = 1'b0;
    repeat (8) step();
    drv_valid = 1'b1;
    repeat (5) begin rand_vec(); step(); end
    drv_valid = 1'b0;
    repeat (20) step();

    // Reset four cycles into a window, then a fresh handshake.
    plan_vec();
    drv_valid = 1'b1;
    drv_first = 1'b1;
    step();
    drv_valid = 1'b0;
    repeat (3) step();
    do_reset();
    repeat (2) step();
    drv_valid = 1'b1;
    rand_vec();
    step();
    drv_valid = 1'b0;
    repeat (15) step();

    // Random traffic with occasional resets.
    repeat (600) begin
      drv_valid = ($urandom_range(0, 2) != 0);
      drv_first = $urandom_range(0, 1) == 1;
      rand_vec();
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end
    drv_valid = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
